irq_ctrl: RTL

- Parametrised interrupt controller: successor to the single-wire IRQ input of the pipeline control decoder.
- Synchronises N external interrupt sources and latches edge events as pending.
- Applies per-channel mask and a global enable, and selects the highest-priority channel.
- Drives a single registered interrupt request into the control decoder, holding it until the pipeline acknowledges injection; then blocks further requests until exception return.
- Memory-mapped register port for the peripheral bus.

---
 rtl/irq_ctrl_if.sv | 25 ++
 rtl/irq_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
// Peripheral register bus plus the pipeline-side interrupt handshake of irq_ctrl.
// The controller takes the slave view; the bus/pipeline side takes the master view.
interface irq_ctrl_if #(
  parameter int ID_W = 3
);
  logic            wr_en;
  logic [1:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            pc_31;
  logic            irq_ack;
  logic            eret;
  logic            irq_req;
  logic [ID_W-1:0] irq_id;

  modport master (
    output wr_en, addr, wdata, pc_31, irq_ack, eret,
    input  rdata, irq_req, irq_id
  );

  modport slave (
    input  wr_en, addr, wdata, pc_31, irq_ack, eret,
    output rdata, irq_req, irq_id
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises N sources, latches edges as pending, masks,
// picks the lowest-index eligible channel and holds one request until ack/eret.
module irq_ctrl #(
  parameter int               N_IRQ       = 8,
  parameter int               ID_W        = 3,
  parameter logic [N_IRQ-1:0] EDGE_MASK   = {N_IRQ{1'b1}},
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_src,
  irq_ctrl_if.slave        bus
);

  localparam int ID_SPAN = 2 ** ID_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q, sync_d;
  logic [N_IRQ-1:0]   prev_q, prev_d;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic               global_en_q, global_en_d;
  logic [ID_W-1:0]    cause_q, cause_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;
  logic               irq_req_q, irq_req_d;
  state_t             state_q, state_d;

  logic [N_IRQ-1:0]   sync_s;
  logic [N_IRQ-1:0]   rise_s;
  logic [N_IRQ-1:0]   w1c_s;
  logic [N_IRQ-1:0]   ack_clr_s;
  logic [N_IRQ-1:0]   elig_s;
  logic [ID_SPAN-1:0] elig_ext_s;
  logic [ID_W-1:0]    sel_s;
  logic               in_service_s;
  logic [31:0]        rdata_s;
  logic               unused_s;

  assign sync_s       = sync_q[SYNC_STAGES-1];
  assign rise_s       = sync_s & ~prev_q;
  assign in_service_s = (state_q == ST_SERVICE);
  assign unused_s     = ^bus.wdata;

  // Synchroniser chain, edge history and pending-bit update.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_src;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
    prev_d = sync_s;

    w1c_s = '0;
    if (bus.wr_en && (bus.addr == 2'd1)) begin
      w1c_s = bus.wdata[N_IRQ-1:0];
    end else begin
      w1c_s = '0;
    end

    ack_clr_s = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_clr_s[i] = (state_q == ST_REQ) && bus.irq_ack && (irq_id_q == ID_W'(i));
    end

    // Edge channels: a new rise beats any clear arriving in the same cycle.
    pending_d = (EDGE_MASK & (rise_s | (pending_q & ~(w1c_s | ack_clr_s))))
              | (~EDGE_MASK & sync_s);
  end

  // Software-visible configuration registers.
  always_comb begin
    mask_d      = mask_q;
    global_en_d = global_en_q;
    if (bus.wr_en) begin
      case (bus.addr)
        2'd0:    mask_d      = bus.wdata[N_IRQ-1:0];
        2'd3:    global_en_d = bus.wdata[0];
        default: mask_d      = mask_q;
      endcase
    end else begin
      mask_d = mask_q;
    end
  end

  // Priority pick and request state machine next-state.
  always_comb begin
    elig_s     = pending_q & mask_q & {N_IRQ{global_en_q}};
    elig_ext_s = '0;
    elig_ext_s[N_IRQ-1:0] = elig_s;

    sel_s = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      sel_s = elig_s[i] ? ID_W'(i) : sel_s;
    end

    state_d  = state_q;
    irq_id_d = irq_id_q;
    cause_d  = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig_s) begin
          state_d  = ST_REQ;
          irq_id_d = sel_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack) begin
          cause_d = irq_id_q;
          state_d = ST_SERVICE;
        end else if (!elig_ext_s[irq_id_q]) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
        state_d = bus.eret ? ST_IDLE : ST_SERVICE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Kernel mode only hides the request; the state machine keeps waiting in REQ.
    irq_req_d = (state_d == ST_REQ) && !bus.pc_31;
  end

  // Register read mux.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.addr)
      2'd0: rdata_s[N_IRQ-1:0] = mask_q;
      2'd1: rdata_s[N_IRQ-1:0] = pending_q;
      2'd2: begin
        rdata_s[31]       = in_service_s;
        rdata_s[ID_W-1:0] = cause_q;
      end
      2'd3:    rdata_s[2:0] = {in_service_s, irq_req_q, global_en_q};
      default: rdata_s      = 32'd0;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      global_en_q <= 1'b0;
      cause_q     <= '0;
      irq_id_q    <= '0;
      irq_req_q   <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      global_en_q <= global_en_d;
      cause_q     <= cause_d;
      irq_id_q    <= irq_id_d;
      irq_req_q   <= irq_req_d;
      state_q     <= state_d;
    end
  end

  assign bus.rdata   = rdata_s;
  assign bus.irq_req = irq_req_q;
  assign bus.irq_id  = irq_id_q;

endmodule
